// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants for the ID-stage hazard scoreboard, forwarding
// unit and decode logic.
//   REG_ADDR_W_DEF : default register address width
//   MAX_LAT_DEF    : default largest non-forwardable result latency
//   LAT_ALU/LAT_LOAD/LAT_MUL : stall cycles a dependant needs per producer class
package cpu_pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int MAX_LAT_DEF    = 3;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

endpackage

// File: rtl/sb_lat_counter.sv
// Single result-latency down-counter for one architectural register.
// Ports:
//   clk     : clock, state on rising edge
//   reset   : synchronous active-high clear
//   set     : load set_val (wins over decrement)
//   set_val : latency to load
//   cnt     : current remaining latency; decrements to zero and holds there
module sb_lat_counter #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [LAT_W-1:0] set_val,
  output logic [LAT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= set_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard. Tracks, per register, how many more cycles
// a recently issued result is not forwardable, and raises stall while any
// decoding source operand reads such a pending register.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   issue_valid     : instruction in ID is valid
//   issue_regwrite  : instruction writes a register
//   issue_dst       : destination register
//   issue_lat       : stall cycles a dependant needs (clamped to MAX_LAT)
//   src_valid       : per-source "operand actually read"
//   src_addr        : packed source addresses, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   flush           : ID instruction squashed this cycle
//   stall           : combinational hold of IF/ID, bubble into ID/EX
//   pending_vec     : bit r set while register r has a non-zero counter
//   stall_cycles    : saturating count of stalled cycles
module id_hazard_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int MAX_LAT    = MAX_LAT_DEF,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_regwrite,
  input  logic [REG_ADDR_W-1:0]         issue_dst,
  input  logic [LAT_W-1:0]              issue_lat,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic                          flush,
  output logic                          stall,
  output logic [(2**REG_ADDR_W)-1:0]    pending_vec,
  output logic [15:0]                   stall_cycles
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0]               lat_clamped;
  logic                           src_hit;
  logic                           rec;

  // Register 0 is hard-wired and never becomes pending.
  assign cnt[0] = '0;

  always_comb begin
    lat_clamped = issue_lat;
    if (issue_lat > LAT_W'(MAX_LAT)) begin
      lat_clamped = LAT_W'(MAX_LAT);
    end
  end

  // Sources are checked against the counters before this instruction's own
  // record, so a self-dependent instruction only stalls on an older producer.
  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] &&
          (src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          (cnt[src_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign stall = src_hit && issue_valid && !flush;

  // A stalled or squashed instruction is re-presented or discarded, so it
  // must not record; zero-latency results are fully forwardable.
  assign rec = issue_valid && issue_regwrite && !stall && !flush &&
               (issue_dst != '0) && (issue_lat != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic set_r;
    assign set_r = rec && (issue_dst == REG_ADDR_W'(r));

    sb_lat_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .set     (set_r),
      .set_val (lat_clamped),
      .cnt     (cnt[r])
    );
  end

  always_comb begin
    pending_vec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_vec[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
